// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status flags and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic Z;
        logic N;
        logic C;
        logic V;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_HOLD
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the issue logic and the sequential ALU.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALU_Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    alu_flags_t       flags;

    modport master (
        output in_valid, A, B, ALU_Sel, out_ready,
        input  in_ready, out_valid, ALU_Out, flags
    );

    modport slave (
        input  in_valid, A, B, ALU_Sel, out_ready,
        output in_ready, out_valid, ALU_Out, flags
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    // prod is the accumulator after the current iteration, so it is final while done is high
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (cnt == LAST);
    assign prod     = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops load the result at accept, MUL runs iteratively.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    alu_op_e            op;
    logic               accept;
    logic               out_valid_q;
    logic [WIDTH-1:0]   alu_out_q;
    alu_flags_t         flags_q;

    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    alu_flags_t         alu_flags;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    alu_flags_t         mul_flags;

    assign op          = alu_op_e'(bus.ALU_Sel);
    assign bus.in_ready = (state == ST_IDLE) || (state == ST_HOLD && bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign mul_start   = accept && (op == OP_MUL);

    assign bus.out_valid = out_valid_q;
    assign bus.ALU_Out   = alu_out_q;
    assign bus.flags     = flags_q;

    // Shifts run in WIDTH+1 bits so the last bit shifted out lands in the spare bit
    always_comb begin
        shamt    = bus.B[SHW-1:0];
        sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
        diff_ext = {1'b0, bus.A} - {1'b0, bus.B};
        shl_ext  = {1'b0, bus.A} << shamt;
        shr_ext  = {bus.A, 1'b0} >> shamt;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_ext[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_XOR: alu_res = bus.A ^ bus.B;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: ;
        endcase
        alu_flags.Z = (alu_res == '0);
        alu_flags.N = alu_res[WIDTH-1];
        alu_flags.C = alu_c;
        alu_flags.V = alu_v;
        mul_flags.Z = (mul_prod[WIDTH-1:0] == '0);
        mul_flags.N = mul_prod[WIDTH-1];
        mul_flags.C = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flags.V = 1'b0;
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.A),
        .b     (bus.B),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // A new accept in HOLD replaces the handshaked result in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
        end else if (state == ST_MUL) begin
            if (mul_done) begin
                state       <= ST_HOLD;
                out_valid_q <= 1'b1;
                alu_out_q   <= mul_prod[WIDTH-1:0];
                flags_q     <= mul_flags;
            end
        end else if (accept) begin
            if (op == OP_MUL) begin
                state       <= ST_MUL;
                out_valid_q <= 1'b0;
            end else begin
                state       <= ST_HOLD;
                out_valid_q <= 1'b1;
                alu_out_q   <= alu_res;
                flags_q     <= alu_flags;
            end
        end else if (state == ST_HOLD && bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a transaction-level reference model checked every cycle.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the consumer should see, plus a pending multiply
    logic         m_valid;
    logic [W-1:0] m_out;
    logic [3:0]   m_flags;
    int           m_mul_cnt;
    logic [W-1:0] m_mul_out;
    logic [3:0]   m_mul_flags;
    logic         m_ready;

    task automatic checkSignal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, full, s;
        int n;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[3:0]);
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin full = ua + ub; r = W'(full); c = full > 65535;
                        s = sa + sb; v = (s > 32767) || (s < -32768); end
            3'd1: begin full = ua - ub; r = W'(full); c = ua < ub;
                        s = sa - sb; v = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = W'(ua << n); c = (n != 0) && (((ua >> (16 - n)) & 1) != 0); end
            3'd6: begin r = W'(ua >> n); c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
            default: begin full = ua * ub; r = W'(full); c = (full >> 16) != 0; end
        endcase
        f = {r == '0, r[W-1], c, v};
    endfunction

    // Compare DUT against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        logic [W-1:0] r;
        logic [3:0]   f;
        logic         hs, acc;
        if (!rst_n) begin
            m_valid   = 1'b0;
            m_out     = '0;
            m_flags   = '0;
            m_mul_cnt = 0;
        end
        m_ready = (m_mul_cnt == 0) && (!m_valid || bus.out_ready);
        checkSignal("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
        checkSignal("model_in_ready", 32'(bus.in_ready), 32'(m_ready));
        checkSignal("model_alu_out", 32'(bus.ALU_Out), 32'(m_out));
        checkSignal("model_flags", 32'(bus.flags), 32'(m_flags));
        if (rst_n) begin
            hs  = m_valid && bus.out_ready;
            acc = bus.in_valid && m_ready;
            if (m_mul_cnt > 0) begin
                m_mul_cnt--;
                if (m_mul_cnt == 0) begin
                    m_valid = 1'b1;
                    m_out   = m_mul_out;
                    m_flags = m_mul_flags;
                end
            end else if (acc) begin
                ref_alu(bus.ALU_Sel, bus.A, bus.B, r, f);
                if (bus.ALU_Sel == 3'd7) begin
                    m_mul_cnt   = W;
                    m_mul_out   = r;
                    m_mul_flags = f;
                    m_valid     = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_out   = r;
                    m_flags = f;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ordy);
        bus.in_valid  = v;
        bus.ALU_Sel   = op;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic er,
                               input logic [W-1:0] eo, input logic [3:0] ef);
        checkSignal({name, "_valid"}, 32'(bus.out_valid), 32'(ev));
        checkSignal({name, "_ready"}, 32'(bus.in_ready), 32'(er));
        checkSignal({name, "_out"}, 32'(bus.ALU_Out), 32'(eo));
        checkSignal({name, "_flags"}, 32'(bus.flags), 32'(ef));
    endtask

    initial begin
        int cycles;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ALU_Sel   = '0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset", 1'b0, 1'b1, 16'h0000, 4'b0000);

        $display("[TB] back-to-back single-cycle ops");
        applyStimulus(1, OP_ADD, 16'h0AB0, 16'h01AC, 1); checkOutput("b2b_add", 1, 1, 16'h0C5C, 4'b0000);
        applyStimulus(1, OP_SUB, 16'h0AB0, 16'h01AC, 1); checkOutput("b2b_sub", 1, 1, 16'h0904, 4'b0000);
        applyStimulus(1, OP_AND, 16'h0AB0, 16'h01AC, 1); checkOutput("b2b_and", 1, 1, 16'h00A0, 4'b0000);
        applyStimulus(1, OP_OR,  16'h0AB0, 16'h01AC, 1); checkOutput("b2b_or",  1, 1, 16'h0BBC, 4'b0000);
        applyStimulus(1, OP_XOR, 16'h0AB0, 16'h01AC, 1); checkOutput("b2b_xor", 1, 1, 16'h0B1C, 4'b0000);
        applyStimulus(0, OP_ADD, 16'h0000, 16'h0000, 1); checkOutput("drain", 0, 1, 16'h0B1C, 4'b0000);

        $display("[TB] flag corners and shifts");
        applyStimulus(1, OP_ADD, 16'h7FFF, 16'h0001, 1); checkOutput("add_ovf",   1, 1, 16'h8000, 4'b0101);
        applyStimulus(1, OP_SUB, 16'h0001, 16'h0002, 1); checkOutput("sub_brw",   1, 1, 16'hFFFF, 4'b0110);
        applyStimulus(1, OP_ADD, 16'hFFFF, 16'h0001, 1); checkOutput("add_carry", 1, 1, 16'h0000, 4'b1010);
        applyStimulus(1, OP_SHL, 16'h8001, 16'h0001, 1); checkOutput("shl1",      1, 1, 16'h0002, 4'b0010);
        applyStimulus(1, OP_SHR, 16'h0003, 16'h0001, 1); checkOutput("shr1",      1, 1, 16'h0001, 4'b0010);
        applyStimulus(1, OP_SHL, 16'h1234, 16'h0010, 1); checkOutput("shl0",      1, 1, 16'h1234, 4'b0000);
        applyStimulus(0, OP_ADD, 16'h0000, 16'h0000, 1); checkOutput("drain2",    0, 1, 16'h1234, 4'b0000);

        $display("[TB] iterative multiply");
        applyStimulus(1, OP_MUL, 16'h0AB0, 16'h01AC, 1); checkOutput("mul_accept", 0, 0, 16'h1234, 4'b0000);
        cycles = 0;
        while (cycles < 20) begin
            applyStimulus(0, OP_MUL, 16'h0000, 16'h0000, 1);
            cycles++;
            if (bus.out_valid) break;
            checkSignal("mul_busy_ready", 32'(bus.in_ready), 32'd0);
        end
        checkSignal("mul_latency", 32'(cycles), 32'd16);
        checkOutput("mul_result", 1, 1, 16'hDE40, 4'b0110);
        applyStimulus(0, OP_ADD, 16'h0000, 16'h0000, 1);

        $display("[TB] backpressure");
        applyStimulus(1, OP_ADD, 16'h0AB0, 16'h01AC, 0); checkOutput("bp_load", 1, 0, 16'h0C5C, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, OP_XOR, 16'(i * 16'h1111), 16'(16'hF0F0 ^ i), 0);
            checkOutput("bp_hold", 1, 0, 16'h0C5C, 4'b0000);
        end
        applyStimulus(1, OP_XOR, 16'h00FF, 16'h0F0F, 1); checkOutput("bp_accept", 1, 1, 16'h0FF0, 4'b0000);

        $display("[TB] reset during multiply");
        applyStimulus(1, OP_MUL, 16'h0AB0, 16'h01AC, 1); checkOutput("mul2_accept", 0, 0, 16'h0FF0, 4'b0000);
        repeat (7) applyStimulus(0, OP_ADD, 16'h0000, 16'h0000, 1);
        rst_n = 1'b0;
        #1 checkOutput("rst_mid_mul", 0, 1, 16'h0000, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, OP_ADD, 16'h0000, 16'h0000, 1);
            checkSignal("no_stale", 32'(bus.out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: the handshaked, multi-cycle successor to the team's combinational 16-bit `alu`. It accepts one operation at a time over a valid/ready input port and returns a registered result with status flags over a valid/ready output port. ADD, SUB, AND, OR, XOR, SHL and SHR complete in one cycle. MUL uses an iterative shift-add unit. The block sits between the datapath issue logic and the register-file writeback.

## Interface
- `WIDTH`, default 16: operand and result width; legal values 4..64, power of two.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands and op are valid.
- `in_ready` out 1: block accepts this cycle.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B; `B[$clog2(WIDTH)-1:0]` is the shift amount for shifts.
- `ALU_Sel` in 3: operation code, `alu_op_e`.
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: consumer takes the result.
- `ALU_Out` out WIDTH: result.
- `flags` out 4: `{Z,N,C,V}`, type `alu_flags_t`.

## Operation
- Opcodes:
  - 0 ADD.
  - 1 SUB (A−B).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL (logical).
  - 6 SHR (logical).
  - 7 MUL (low WIDTH bits of the unsigned product).
- All arithmetic is modulo 2^WIDTH.
- Flags:
  - Z: result == 0.
  - N: result[WIDTH-1].
  - C for ADD: carry-out.
  - C for SUB: borrow, i.e. A < B unsigned.
  - C for SHL/SHR: last bit shifted out; 0 when the shift amount is 0.
  - C for MUL: 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - C for logic ops: 0.
  - V: signed overflow for ADD/SUB; 0 for all other ops.
- FSM states: IDLE, MUL, HOLD.
  - IDLE → HOLD on accepting a non-MUL op.
  - IDLE → MUL on accepting a MUL op.
  - MUL → HOLD after WIDTH iterations.
  - HOLD → IDLE on an output handshake with no new accept.
  - HOLD → HOLD or MUL on an output handshake with a simultaneous new accept.
- `in_ready` = (state == IDLE) || (state == HOLD && out_ready).
- `in_ready` is low throughout MUL.
- Exactly one operation is in flight; there is no queue.
- A, B and ALU_Sel are captured at accept; later input changes have no effect.
- The iteration counter is $clog2(WIDTH)+1 bits and runs 0..WIDTH-1.
- Reset at any time, including mid-MUL, aborts the operation. No partial result is ever emitted.

## Timing
- Reset values:
  - `out_valid` = 0.
  - `ALU_Out` = 0.
  - `flags` = 0.
  - `in_ready` = 1.
  - State = IDLE.
  - Counter = 0.
- Accept happens at rising edge k where `in_valid && in_ready`.
- Non-MUL latency: `out_valid` = 1 after edge k+1 (one cycle).
- MUL latency: iterations run on edges k+1..k+WIDTH; `out_valid` = 1 after edge k+WIDTH. For WIDTH = 16 this is 16 cycles.
- `ALU_Out` and `flags` are register outputs with no combinational path from the inputs. They change only at accept-result load and are stable while `out_valid && !out_ready`.
- Output handshake completes at an edge where `out_valid && out_ready`.
- `out_valid` drops at the next edge unless a non-MUL op was accepted at the same edge. In that case `out_valid` stays 1 and the new result appears (back-to-back throughput of 1 op/cycle).
- A MUL accepted at the same edge as an output handshake drops `out_valid` until the MUL completes.
- `in_valid` while `in_ready` = 0 is ignored. The producer must hold its request; the block does not latch it.

## Structure
- The `alu_pkg` package holds:
  - `alu_op_e`: 3-bit enum, values 0..7 as above.
  - `alu_flags_t`: packed struct `{Z,N,C,V}`.
  - `alu_state_e`: IDLE, MUL, HOLD.
- Sub-module `alu_mul_iter`:
  - Parameter: WIDTH.
  - Ports: `clk`, `rst_n`, `start`, `a`, `b`, `done`, `prod[2*WIDTH-1:0]`.
  - Implements a shift-add multiplier, one bit per cycle.
  - `done` pulses for one cycle on the WIDTH-th iteration.
- The top level owns the FSM, the single-cycle datapath, flag generation and the handshake.

## Test plan
- Reset then op sequence, WIDTH=16, A=0x0AB0, B=0x01AC, ops 0..4 back-to-back with `out_ready`=1:
  - ADD → 0x0C5C.
  - SUB → 0x0904.
  - AND → 0x00A0.
  - OR → 0x0BBC.
  - XOR → 0x0B1C.
  - One result per cycle; all flags `{Z,N,C,V}` = 0000.
- Flag corners:
  - ADD 0x7FFF+0x0001 → 0x8000, flags `{Z,N,C,V}` = 0101.
  - SUB 0x0001−0x0002 → 0xFFFF, flags 0110.
  - ADD 0xFFFF+0x0001 → 0x0000, flags 1010.
- Shifts:
  - SHL 0x8001 by 1 → 0x0002, C=1.
  - SHR 0x0003 by 1 → 0x0001, C=1.
  - SHL by 0 → result equals A, C=0.
- MUL 0x0AB0×0x01AC → 0xDE40, C=1.
  - `out_valid` rises exactly 16 cycles after accept.
  - `in_ready` = 0 for the whole multiply.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 and changing A/B.
  - `ALU_Out` and `flags` stay stable; `in_ready` = 0.
  - On the `out_ready` pulse, the new op is accepted at the same edge.
- Deassert `rst_n` mid-MUL at iteration 7 → outputs clear immediately; after release, `in_ready`=1 and no stale result appears.
